// File: rtl/cpu_pkg.sv
// Shared CPU encodings for the execute stage.
// Covers the ALU ops, result-select codes and forwarding-select codes.
package cpu_pkg;

   localparam int WIDTH = 16;
   localparam int RADDR = 4;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLL = 3'b101,
      ALU_SRL = 3'b110,
      ALU_CMP = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC  = 2'b10
   } result_src_e;

   typedef enum logic [1:0] {
      FWD_ID  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_ID2 = 2'b11
   } fwd_sel_e;

endpackage

// File: rtl/execute_stage_if.sv
// Bundle of ID/EX inputs, forwarding inputs and EX/MEM outputs of the execute stage.
interface execute_stage_if;
   import cpu_pkg::*;

   logic              stallM;
   logic [WIDTH-1:0]  RD1E;
   logic [WIDTH-1:0]  RD2E;
   logic [WIDTH-1:0]  immExtE;
   logic [WIDTH-1:0]  PCE;
   logic [WIDTH-1:0]  PCPlus2E;
   logic [RADDR-1:0]  RdE;
   logic              regWriteE;
   logic              memWriteE;
   logic              jumpE;
   logic              branchE;
   logic              aluSrcE;
   alu_op_e           aluControlE;
   result_src_e       resultSrcE;
   fwd_sel_e          forwardAE;
   fwd_sel_e          forwardBE;
   logic [WIDTH-1:0]  ResultW;

   logic              PCSrcE;
   logic [WIDTH-1:0]  PCTargetE;
   logic              flagZ;
   logic              flagN;
   logic [WIDTH-1:0]  ALUResultM;
   logic [WIDTH-1:0]  WriteDataM;
   logic [WIDTH-1:0]  PCPlus2M;
   logic [RADDR-1:0]  RdM;
   logic              regWriteM;
   logic              memWriteM;
   result_src_e       resultSrcM;

   modport slave (
      input  stallM, RD1E, RD2E, immExtE, PCE, PCPlus2E, RdE,
             regWriteE, memWriteE, jumpE, branchE, aluSrcE,
             aluControlE, resultSrcE, forwardAE, forwardBE, ResultW,
      output PCSrcE, PCTargetE, flagZ, flagN, ALUResultM, WriteDataM,
             PCPlus2M, RdM, regWriteM, memWriteM, resultSrcM
   );

   modport master (
      output stallM, RD1E, RD2E, immExtE, PCE, PCPlus2E, RdE,
             regWriteE, memWriteE, jumpE, branchE, aluSrcE,
             aluControlE, resultSrcE, forwardAE, forwardBE, ResultW,
      input  PCSrcE, PCTargetE, flagZ, flagN, ALUResultM, WriteDataM,
             PCPlus2M, RdM, regWriteM, memWriteM, resultSrcM
   );

endinterface

// File: rtl/exe_alu.sv
// Combinational 16-bit ALU; Z/N describe the result so CMP can reuse the subtract path.
module exe_alu
   import cpu_pkg::*;
(
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  alu_op_e          i_op,
   output logic [WIDTH-1:0] o_y,
   output logic             o_z,
   output logic             o_n
);

   localparam int SHW = $clog2(WIDTH);

   // Shifts use only the low bits of B so oversized amounts wrap instead of clearing.
   always_comb begin
      o_y = '0;
      case (i_op)
         ALU_ADD: o_y = i_a + i_b;
         ALU_SUB: o_y = i_a - i_b;
         ALU_AND: o_y = i_a & i_b;
         ALU_OR:  o_y = i_a | i_b;
         ALU_XOR: o_y = i_a ^ i_b;
         ALU_SLL: o_y = i_a << i_b[SHW-1:0];
         ALU_SRL: o_y = i_a >> i_b[SHW-1:0];
         ALU_CMP: o_y = i_a - i_b;
         default: o_y = '0;
      endcase
   end

   assign o_z = (o_y == '0);
   assign o_n = o_y[WIDTH-1];

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, N/Z flag register, branch resolution
// and the EX/MEM pipeline register.
module execute_stage
   import cpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   execute_stage_if.slave   bus
);

   logic [WIDTH-1:0] w_srcA;
   logic [WIDTH-1:0] w_writeDataE;
   logic [WIDTH-1:0] w_srcB;
   logic [WIDTH-1:0] w_aluY;
   logic             w_aluZ;
   logic             w_aluN;
   logic             w_isCmp;

   logic [WIDTH-1:0] r_aluResultM;
   logic [WIDTH-1:0] r_writeDataM;
   logic [WIDTH-1:0] r_pcPlus2M;
   logic [RADDR-1:0] r_rdM;
   logic             r_regWriteM;
   logic             r_memWriteM;
   result_src_e      r_resultSrcM;
   logic             r_flagZ;
   logic             r_flagN;

   // The MEM-stage forward taps our own EX/MEM register.
   always_comb begin
      w_srcA       = bus.RD1E;
      w_writeDataE = bus.RD2E;
      case (bus.forwardAE)
         FWD_WB:  w_srcA = bus.ResultW;
         FWD_MEM: w_srcA = r_aluResultM;
         default: w_srcA = bus.RD1E;
      endcase
      case (bus.forwardBE)
         FWD_WB:  w_writeDataE = bus.ResultW;
         FWD_MEM: w_writeDataE = r_aluResultM;
         default: w_writeDataE = bus.RD2E;
      endcase
   end

   assign w_srcB  = bus.aluSrcE ? bus.immExtE : w_writeDataE;
   assign w_isCmp = (bus.aluControlE == ALU_CMP);

   exe_alu u_alu (
      .i_a  (w_srcA),
      .i_b  (w_srcB),
      .i_op (bus.aluControlE),
      .o_y  (w_aluY),
      .o_z  (w_aluZ),
      .o_n  (w_aluN)
   );

   // CMP writes only the flags, never a register, so its regWrite is masked here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_aluResultM <= '0;
         r_writeDataM <= '0;
         r_pcPlus2M   <= '0;
         r_rdM        <= '0;
         r_regWriteM  <= 1'b0;
         r_memWriteM  <= 1'b0;
         r_resultSrcM <= RES_ALU;
         r_flagZ      <= 1'b0;
         r_flagN      <= 1'b0;
      end else if (!bus.stallM) begin
         r_aluResultM <= w_aluY;
         r_writeDataM <= w_writeDataE;
         r_pcPlus2M   <= bus.PCPlus2E;
         r_rdM        <= bus.RdE;
         r_regWriteM  <= bus.regWriteE & ~w_isCmp;
         r_memWriteM  <= bus.memWriteE;
         r_resultSrcM <= bus.resultSrcE;
         if (w_isCmp) begin
            r_flagZ <= w_aluZ;
            r_flagN <= w_aluN;
         end
      end
   end

   // Branches read the registered flags, so a CMP is seen by the following instruction.
   assign bus.PCSrcE     = bus.jumpE | (bus.branchE & r_flagZ);
   assign bus.PCTargetE  = bus.PCE;
   assign bus.flagZ      = r_flagZ;
   assign bus.flagN      = r_flagN;
   assign bus.ALUResultM = r_aluResultM;
   assign bus.WriteDataM = r_writeDataM;
   assign bus.PCPlus2M   = r_pcPlus2M;
   assign bus.RdM        = r_rdM;
   assign bus.regWriteM  = r_regWriteM;
   assign bus.memWriteM  = r_memWriteM;
   assign bus.resultSrcM = r_resultSrcM;

endmodule
